// File: rtl/mem_port_arbiter.sv
// Arbitrates the single cache/memory port between instruction fetch and load/store.
// Data side wins by default; a consecutive-grant limit keeps a waiting fetch from starving.
//
// state | meaning
// IDLE  | port free, pick next requester
// FETCH | fetch transaction in flight on the port
// DATA  | load/store transaction in flight on the port
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  input  logic                flush_i,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                memOp_done_o,
  output logic                arb_eqmem_o,
  output logic                stall_fetch_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              memop_done_q, memop_done_d;
  logic [CNT_W-1:0]  fair_cnt_q, fair_cnt_d;
  logic              drop_q, drop_d;

  logic eff_if, eff_dm, grant_dm, grant_if;

  // A requester whose done pulse is high this cycle is masked so it cannot re-issue.
  assign eff_if   = if_req_i & ~if_done_q & ~flush_i;
  assign eff_dm   = dm_req_i & ~memop_done_q;
  assign grant_dm = eff_dm & ~(eff_if & (fair_cnt_q == CNT_MAX));
  assign grant_if = eff_if & ~grant_dm;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    memop_done_d = 1'b0;
    fair_cnt_d   = fair_cnt_q;
    drop_d       = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_be_d    = dm_be_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i && (fair_cnt_q != CNT_MAX)) begin
            fair_cnt_d = fair_cnt_q + 1'b1;
          end
        end else if (grant_if) begin
          state_d     = ST_FETCH;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          fair_cnt_d  = '0;
        end
      end

      ST_FETCH: begin
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          // A flush seen at any point of the transaction, including the ack cycle, discards it.
          if (!drop_q && !flush_i) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end
      end

      ST_DATA: begin
        if (mem_ack_i) begin
          state_d      = ST_IDLE;
          mem_req_d    = 1'b0;
          memop_done_d = 1'b1;
          dm_rdata_d   = mem_rdata_i;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (!if_req_i) begin
      fair_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      memop_done_q <= 1'b0;
      fair_cnt_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      memop_done_q <= memop_done_d;
      fair_cnt_q   <= fair_cnt_d;
      drop_q       <= drop_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign if_rdata_o    = if_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign if_done_o     = if_done_q;
  assign memOp_done_o  = memop_done_q;
  assign arb_eqmem_o   = (state_q == ST_DATA);
  assign stall_fetch_o = if_req_i & ~if_done_q;

endmodule
